// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
//
// Round-robin, packet-atomic scheduler draining N show-ahead sync FIFOs into a
// single valid/ready output stream. A source keeps the grant until its
// end-of-packet beat has been popped, or until MAX_PKT beats have been popped.
// In the second case the beat is forced to end the packet and err_o is set.
// Priority then rotates to the source after the one that was served.
//
// Ports
//   clk_i     sole clock, rising edge
//   rst_n_i   asynchronous active-low reset
//   empty_i   per-source FIFO empty flags
//   data_i    per-source show-ahead head words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   last_i    per-source end-of-packet flag of the head word
//   rd_en_o   one-hot pop strobe to the granted FIFO (combinational)
//   valid_o   output register holds a beat
//   data_o    output beat
//   last_o    output beat ends a packet
//   src_o     index of the source that produced data_o
//   ready_i   consumer accepts the beat when valid_o && ready_i
//   err_o     sticky flag, a packet was truncated at MAX_PKT
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | searching for a non-empty source, starting at ptr
// GRANT | popping beats from gnt until a beat with last_o is popped
module rr_packet_arbiter #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_PKT    = 16,
   localparam int SW        = (N > 1) ? $clog2(N) : 1,
   localparam int CW        = $clog2(MAX_PKT + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [N-1:0]            empty_i,
   input  logic [N*DATA_WIDTH-1:0] data_i,
   input  logic [N-1:0]            last_i,
   output logic [N-1:0]            rd_en_o,
   output logic                    valid_o,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    last_o,
   output logic [SW-1:0]           src_o,
   input  logic                    ready_i,
   output logic                    err_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           gnt_q, gnt_d;
   logic [SW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   logic                    valid_d;
   logic [DATA_WIDTH-1:0]   data_d;
   logic                    last_d;
   logic [SW-1:0]           src_d;
   logic                    err_d;

   logic                    found;
   logic [SW-1:0]           sel;
   logic                    head_empty;
   logic                    head_last;
   logic [DATA_WIDTH-1:0]   head_data;
   logic                    slot_free;
   logic                    pop;
   logic                    at_max;
   logic                    end_beat;
   logic [SW-1:0]           gnt_inc;

   // Rotating search: first non-empty source at or above ptr, otherwise the
   // lowest non-empty source (the wrap-around part of the circle).
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && !empty_i[i] && (SW'(i) >= ptr_q)) begin
            found = 1'b1;
            sel   = SW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && !empty_i[i]) begin
            found = 1'b1;
            sel   = SW'(i);
         end
      end
   end

   // Only the granted source's inputs are looked at; the rest are don't-care.
   always_comb begin
      head_empty = 1'b1;
      head_last  = 1'b0;
      head_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_q == SW'(i)) begin
            head_empty = empty_i[i];
            head_last  = last_i[i];
            head_data  = data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign slot_free = !valid_o || ready_i;
   assign pop       = (state_q == GRANT) && !head_empty && slot_free;
   assign at_max    = (cnt_q == CW'(MAX_PKT - 1));
   assign end_beat  = head_last || at_max;
   assign gnt_inc   = (gnt_q == SW'(N - 1)) ? '0 : gnt_q + 1'b1;

   always_comb begin
      rd_en_o = '0;
      for (int i = 0; i < N; i++) begin
         rd_en_o[i] = pop && (gnt_q == SW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_o;
      data_d  = data_o;
      last_d  = last_o;
      src_d   = src_o;
      err_d   = err_o;

      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = sel;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (pop) begin
               data_d  = head_data;
               src_d   = gnt_q;
               valid_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               last_d  = end_beat;
               if (at_max && !head_last) begin
                  err_d = 1'b1;
               end
               if (end_beat) begin
                  ptr_d   = gnt_inc;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Consumer took the beat and nothing refilled the register.
      if (!pop && valid_o && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         valid_o <= 1'b0;
         data_o  <= '0;
         last_o  <= 1'b0;
         src_o   <= '0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_o <= valid_d;
         data_o  <= data_d;
         last_o  <= last_d;
         src_o   <= src_d;
         err_o   <= err_d;
      end
   end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Testbench for rr_packet_arbiter: behavioural FIFOs feed the arbiter, the
// accepted output beats are collected and compared against directed
// expectations and against a packet-level round-robin reference model.
module tb_rr_packet_arbiter;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int MAX_PKT = 16;
   localparam int SW      = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      empty;
   logic [N*DW-1:0]   data_in;
   logic [N-1:0]      last_in;
   logic [N-1:0]      rd_en;
   logic              valid;
   logic [DW-1:0]     data_out;
   logic              last_out;
   logic [SW-1:0]     src;
   logic              ready;
   logic              err;

   always #5 clk = ~clk;

   rr_packet_arbiter #(.N(N), .DATA_WIDTH(DW), .MAX_PKT(MAX_PKT)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .empty_i (empty),
      .data_i  (data_in),
      .last_i  (last_in),
      .rd_en_o (rd_en),
      .valid_o (valid),
      .data_o  (data_out),
      .last_o  (last_out),
      .src_o   (src),
      .ready_i (ready),
      .err_o   (err)
   );

   typedef struct {
      logic [N-1:0]  pops;
      logic          valid;
      logic          ready;
      logic [DW-1:0] data;
      logic          last;
      logic          err;
   } samp_t;

   typedef struct {
      int            src;
      logic [DW-1:0] data;
      logic          last;
      logic          err;
   } beat_t;

   logic [DW:0] mem [N][64];
   logic [5:0]  rd_p [N];
   logic [5:0]  wr_p [N];

   beat_t obs_q[$];
   int    obs_cyc[$];
   beat_t exp_q[$];
   int    cyc;
   int    checks;
   int    errors;

   always_comb begin
      empty   = '1;
      data_in = '0;
      last_in = '0;
      for (int i = 0; i < N; i++) begin
         empty[i]             = (rd_p[i] == wr_p[i]);
         data_in[i*DW +: DW]  = mem[i][rd_p[i]][DW-1:0];
         last_in[i]           = mem[i][rd_p[i]][DW];
      end
   end

   task automatic push(input int s, input logic [DW-1:0] d, input logic l);
      mem[s][wr_p[s]] = {l, d};
      wr_p[s] = wr_p[s] + 6'd1;
   endtask

   // One clock: sample at the falling edge, then pop the FIFOs that were
   // strobed and return 1 time unit after the rising edge.
   task automatic tick(output samp_t s);
      beat_t b;
      @(negedge clk);
      s.pops  = rd_en;
      s.valid = valid;
      s.ready = ready;
      s.data  = data_out;
      s.last  = last_out;
      s.err   = err;
      if (valid && ready) begin
         b.src  = int'(src);
         b.data = data_out;
         b.last = last_out;
         b.err  = err;
         obs_q.push_back(b);
         obs_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (s.pops[i]) rd_p[i] = rd_p[i] + 6'd1;
      end
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         rd_p[i] = '0;
         wr_p[i] = '0;
      end
      obs_q.delete();
      obs_cyc.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_until(input int nbeats, input int budget, input string name);
      samp_t s;
      int    n;
      n = 0;
      while (obs_q.size() < nbeats && n < budget) begin
         tick(s);
         n++;
      end
      checks++;
      if (obs_q.size() < nbeats) begin
         errors++;
         $display("FAIL %s timeout: got %0d beats, required %0d", name, obs_q.size(), nbeats);
      end
   endtask

   // Packet-level reference: serve non-empty sources in circular order from
   // ptr, each for one packet of at most MAX_PKT beats, then move ptr past it.
   task automatic build_expected(output logic e);
      logic [5:0]  p [N];
      int          ptr;
      int          found;
      int          n;
      int          guard;
      int          s2;
      logic [DW:0] b;
      logic        lst;
      beat_t       x;
      e = 1'b0;
      ptr = 0;
      guard = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) p[i] = rd_p[i];
      while (guard < 1000) begin
         guard++;
         found = -1;
         for (int k = 0; k < N; k++) begin
            s2 = (ptr + k) % N;
            if (found < 0 && p[s2] != wr_p[s2]) found = s2;
         end
         if (found < 0) break;
         n = 0;
         do begin
            b = mem[found][p[found]];
            p[found] = p[found] + 6'd1;
            n++;
            lst = b[DW] || (n == MAX_PKT);
            if (n == MAX_PKT && !b[DW]) e = 1'b1;
            x.src  = found;
            x.data = b[DW-1:0];
            x.last = lst;
            x.err  = 1'b0;
            exp_q.push_back(x);
         end while (!lst && p[found] != wr_p[found]);
         ptr = (found + 1) % N;
      end
   endtask

   task automatic test_reset();
      samp_t s;
      apply_reset();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (rd_en !== '0) begin errors++; $display("FAIL reset_rd_en got %b want 0000", rd_en); end
      checks++; if (src !== '0) begin errors++; $display("FAIL reset_src got %0d want 0", src); end
      push(0, 8'h5A, 1'b0);
      push(0, 8'hA5, 1'b0);
      push(0, 8'h3C, 1'b1);
      repeat (3) tick(s);
      checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL pre_reset_data got %h want a5", data_out); end
      checks++; if (rd_en !== 4'b0001) begin errors++; $display("FAIL pre_reset_rd_en got %b want 0001", rd_en); end
      rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", valid); end
      checks++; if (rd_en !== '0) begin errors++; $display("FAIL async_reset_rd_en got %b want 0000", rd_en); end
      checks++; if (data_out !== '0 || last_out !== 1'b0 || src !== '0) begin
         errors++; $display("FAIL async_reset_out got data=%h last=%b src=%0d want 0", data_out, last_out, src);
      end
      @(posedge clk);
      #1;
      checks++; if (rd_en !== '0 || valid !== 1'b0) begin
         errors++; $display("FAIL held_reset got rd_en=%b valid=%b want 0", rd_en, valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_packet();
      samp_t s;
      apply_reset();
      push(1, 8'hA1, 1'b0);
      push(1, 8'hB2, 1'b0);
      push(1, 8'hC3, 1'b1);
      tick(s);
      checks++; if (s.pops !== 4'b0000) begin errors++; $display("FAIL single_idle_rd_en got %b want 0000", s.pops); end
      for (int k = 0; k < 3; k++) begin
         tick(s);
         checks++; if (s.pops !== 4'b0010) begin errors++; $display("FAIL single_rd_en[%0d] got %b want 0010", k, s.pops); end
      end
      tick(s);
      checks++; if (s.pops !== 4'b0000) begin errors++; $display("FAIL single_release_rd_en got %b want 0000", s.pops); end
      tick(s);
      checks++;
      if (obs_q.size() != 3) begin
         errors++; $display("FAIL single_count got %0d want 3", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0].data !== 8'hA1 || obs_q[1].data !== 8'hB2 || obs_q[2].data !== 8'hC3 ||
             obs_q[0].src != 1 || obs_q[1].src != 1 || obs_q[2].src != 1 ||
             obs_q[0].last !== 1'b0 || obs_q[1].last !== 1'b0 || obs_q[2].last !== 1'b1) begin
            errors++;
            $display("FAIL single_beats got %h/%0d/%b %h/%0d/%b %h/%0d/%b want a1/1/0 b2/1/0 c3/1/1",
                     obs_q[0].data, obs_q[0].src, obs_q[0].last, obs_q[1].data, obs_q[1].src, obs_q[1].last,
                     obs_q[2].data, obs_q[2].src, obs_q[2].last);
         end
      end
      // ptr now points at source 2, so 2 wins over 0.
      push(0, 8'h01, 1'b1);
      push(2, 8'h02, 1'b1);
      run_until(4, 20, "single_ptr");
      if (obs_q.size() >= 4) begin
         checks++; if (obs_q[3].src != 2) begin errors++; $display("FAIL single_ptr got src %0d want 2", obs_q[3].src); end
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 8'(r * 16 + i), 1'b1);
      run_until(8, 100, "fair");
      for (int k = 0; k < obs_q.size() && k < 8; k++) begin
         checks++;
         if (obs_q[k].src != k % N || obs_q[k].data !== 8'((k / N) * 16 + k % N)) begin
            errors++;
            $display("FAIL fair_order[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, obs_q[k].src, obs_q[k].data, k % N, 8'((k / N) * 16 + k % N));
         end
         if (k > 0) begin
            checks++;
            if (obs_cyc[k] - obs_cyc[k-1] != 2) begin
               errors++; $display("FAIL fair_gap[%0d] got %0d cycles want 2", k, obs_cyc[k] - obs_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      samp_t         s;
      logic          stalled;
      logic [DW-1:0] held;
      int            nstall;
      apply_reset();
      for (int k = 0; k < 4; k++) push(0, 8'(8'h40 + k), (k == 3));
      stalled = 1'b0;
      held    = '0;
      nstall  = 0;
      for (int c = 0; c < 12; c++) begin
         ready = !(c >= 2 && c <= 4);
         tick(s);
         if (stalled) begin
            checks++;
            if (s.valid !== 1'b1 || s.data !== held) begin
               errors++; $display("FAIL bp_hold c%0d got valid=%b data=%h want 1/%h", c, s.valid, s.data, held);
            end
         end
         stalled = s.valid && !s.ready;
         held    = s.data;
         if (stalled) begin
            nstall++;
            checks++;
            if (s.pops !== '0) begin errors++; $display("FAIL bp_rd_en c%0d got %b want 0000", c, s.pops); end
         end
      end
      ready = 1'b1;
      checks++; if (nstall != 3) begin errors++; $display("FAIL bp_stall_cycles got %0d want 3", nstall); end
      checks++;
      if (obs_q.size() != 4) begin
         errors++; $display("FAIL bp_count got %0d want 4", obs_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].data !== 8'(8'h40 + k) || obs_q[k].last !== (k == 3)) begin
               errors++; $display("FAIL bp_beat[%0d] got %h/%b want %h/%b", k, obs_q[k].data, obs_q[k].last, 8'(8'h40 + k), (k == 3));
            end
         end
      end
   endtask

   task automatic test_atomicity();
      samp_t s;
      logic  bad;
      apply_reset();
      push(2, 8'd1, 1'b0);
      push(2, 8'd2, 1'b0);
      push(3, 8'h31, 1'b1);
      bad = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(s);
         if (s.pops[3]) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL atom_grant3 got pop on source 3 want none"); end
      checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL atom_partial got %0d beats want 2", obs_q.size()); end
      push(2, 8'd3, 1'b0);
      push(2, 8'd4, 1'b0);
      push(2, 8'd5, 1'b1);
      run_until(6, 40, "atom");
      for (int k = 0; k < obs_q.size() && k < 6; k++) begin
         checks++;
         if (obs_q[k].src != ((k < 5) ? 2 : 3) || obs_q[k].data !== ((k < 5) ? 8'(k + 1) : 8'h31) ||
             obs_q[k].last !== (k >= 4)) begin
            errors++;
            $display("FAIL atom_beat[%0d] got src=%0d data=%h last=%b", k, obs_q[k].src, obs_q[k].data, obs_q[k].last);
         end
      end
   endtask

   task automatic test_truncation();
      int            es;
      logic [DW-1:0] ed;
      logic          el;
      apply_reset();
      for (int k = 0; k < 20; k++) push(0, 8'(k + 1), 1'b0);
      push(1, 8'hEE, 1'b1);
      run_until(21, 200, "trunc");
      for (int k = 0; k < obs_q.size() && k < 21; k++) begin
         if (k < 16)       begin es = 0; ed = 8'(k + 1); el = (k == 15); end
         else if (k == 16) begin es = 1; ed = 8'hEE;    el = 1'b1;     end
         else              begin es = 0; ed = 8'(k);    el = 1'b0;     end
         checks++;
         if (obs_q[k].src != es || obs_q[k].data !== ed || obs_q[k].last !== el) begin
            errors++;
            $display("FAIL trunc_beat[%0d] got %0d/%h/%b want %0d/%h/%b", k, obs_q[k].src, obs_q[k].data,
                     obs_q[k].last, es, ed, el);
         end
      end
      if (obs_q.size() >= 16) begin
         checks++; if (obs_q[14].err !== 1'b0) begin errors++; $display("FAIL trunc_err_early got %b want 0", obs_q[14].err); end
         checks++; if (obs_q[15].err !== 1'b1) begin errors++; $display("FAIL trunc_err_set got %b want 1", obs_q[15].err); end
      end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL trunc_err_sticky got %b want 1", err); end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      for (int k = 0; k < 18; k++) push(2, 8'(8'h80 + k), 1'b0);
      for (int k = 0; k < 5; k++)  push(3, 8'(8'hC0 + k), (k == 4));
      run_until(18, 200, "rmid");
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rmid_err_before got %b want 1", err); end
      checks++; if (rd_en !== 4'b1000) begin errors++; $display("FAIL rmid_rd_en_before got %b want 1000", rd_en); end
      rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err); end
      checks++; if (rd_en !== '0) begin errors++; $display("FAIL rmid_rd_en got %b want 0000", rd_en); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs_q.delete();
      obs_cyc.delete();
      run_until(1, 20, "rmid_restart");
      if (obs_q.size() >= 1) begin
         checks++;
         if (obs_q[0].src != 2 || obs_q[0].data !== 8'h90) begin
            errors++; $display("FAIL rmid_restart got src=%0d data=%h want 2/90", obs_q[0].src, obs_q[0].data);
         end
      end
   endtask

   task automatic test_random();
      samp_t s;
      logic  exp_err;
      int    npk;
      int    len;
      int    n;
      int    onehot_bad;
      for (int it = 0; it < 3; it++) begin
         apply_reset();
         for (int i = 0; i < N; i++) begin
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               len = $urandom_range(1, 20);
               for (int k = 0; k < len; k++) push(i, 8'($urandom), (k == len - 1));
            end
         end
         build_expected(exp_err);
         n = 0;
         onehot_bad = 0;
         while (obs_q.size() < exp_q.size() && n < 4000) begin
            ready = ($urandom_range(0, 3) != 0);
            tick(s);
            if ($countones(s.pops) > 1) onehot_bad++;
            n++;
         end
         ready = 1'b1;
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand%0d_count got %0d want %0d", it, obs_q.size(), exp_q.size());
         end
         for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].src != exp_q[k].src || obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last) begin
               errors++;
               $display("FAIL rand%0d_beat[%0d] got %0d/%h/%b want %0d/%h/%b", it, k, obs_q[k].src, obs_q[k].data,
                        obs_q[k].last, exp_q[k].src, exp_q[k].data, exp_q[k].last);
            end
         end
         checks++; if (err !== exp_err) begin errors++; $display("FAIL rand%0d_err got %b want %b", it, err, exp_err); end
         checks++; if (onehot_bad != 0) begin errors++; $display("FAIL rand%0d_onehot got %0d bad cycles want 0", it, onehot_bad); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      ready  = 1'b1;
      for (int i = 0; i < N; i++) begin
         rd_p[i] = '0;
         wr_p[i] = '0;
      end
      test_reset();
      test_single_packet();
      test_fairness();
      test_back_pressure();
      test_atomicity();
      test_truncation();
      test_reset_mid_packet();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
